// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: shares one RAM port between an icache and a dcache.
// The dcache has priority, bounded by a streak limit so a waiting icache is not starved.
module mem_arbiter #(
  parameter int DSTREAK_MAX = 4
) (
  input  logic        CLK,
  input  logic        nRST,
  // icache
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload,
  // dcache
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload,
  // RAM
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate,
  output logic        ramerr
);

  typedef enum logic [1:0] {IDLE, DGRANT, IGRANT} state_t;

  localparam logic [2:0] L_DMAX = 3'(DSTREAK_MAX);

  state_t     r_state;
  logic [2:0] r_dstreak;
  logic       r_ramerr;

  logic w_dreq;
  logic w_access;
  logic w_error;
  logic w_dsel;
  logic w_isel;
  logic w_dstreak_full;

  assign w_dreq         = dREN | dWEN;
  assign w_access       = (ramstate == 2'd2);
  assign w_error        = (ramstate == 2'd3);
  assign w_dsel         = (r_state == DGRANT) && w_dreq;
  assign w_isel         = (r_state == IGRANT) && iREN;
  assign w_dstreak_full = (r_dstreak >= L_DMAX);

  // A grant with its request withdrawn drives nothing, so an abort never reaches the RAM.
  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = 32'd0;
    ramstore = 32'd0;
    iwait    = 1'b1;
    dwait    = 1'b1;
    iload    = 32'd0;
    dload    = 32'd0;
    if (w_dsel) begin
      ramWEN   = dWEN;
      ramREN   = dREN & ~dWEN;
      ramaddr  = daddr;
      ramstore = dstore;
      dwait    = ~w_access;
      dload    = w_access ? ramload : 32'd0;
    end else if (w_isel) begin
      ramREN   = 1'b1;
      ramaddr  = iaddr;
      iwait    = ~w_access;
      iload    = w_access ? ramload : 32'd0;
    end
  end

  assign ramerr = r_ramerr;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state   <= IDLE;
      r_dstreak <= 3'd0;
      r_ramerr  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_dreq && !(iREN && r_dstreak == L_DMAX)) r_state <= DGRANT;
          else if (iREN)                                r_state <= IGRANT;
        end
        DGRANT: begin
          if (!w_dreq) begin
            r_state <= IDLE;
          end else if (w_error) begin
            r_ramerr <= 1'b1;
          end else if (w_access && daddr[2]) begin
            // Second word of the block: release and account for the waiting icache.
            r_state <= IDLE;
            if (iREN) r_dstreak <= w_dstreak_full ? L_DMAX : r_dstreak + 3'd1;
            else      r_dstreak <= 3'd0;
          end
        end
        IGRANT: begin
          if (!iREN) begin
            r_state <= IDLE;
          end else if (w_error) begin
            r_ramerr <= 1'b1;
          end else if (w_access) begin
            r_state   <= IDLE;
            r_dstreak <= 3'd0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter, checked cycle by cycle against an ownership-level
// model; directed passes cover priority, block lock, fairness, write, error and reset.
module tb_mem_arbiter;

  localparam int DMAX = 4;

  logic        clk = 1'b0;
  logic        nrst;
  logic        iren, dren, dwen;
  logic [31:0] iaddr, daddr, dstore, ramload;
  logic [1:0]  ramstate;
  logic        iwait, dwait, ramren, ramwen, ramerr;
  logic [31:0] iload, dload, ramaddr, ramstore;

  int errors = 0;
  int checks = 0;

  // Model: who owns the RAM (0 none, 1 dcache, 2 icache), dcache wins since icache was served, error flag.
  int owner  = 0;
  int streak = 0;
  bit err    = 1'b0;

  always #5 clk = ~clk;

  mem_arbiter #(.DSTREAK_MAX(DMAX)) dut (
    .CLK(clk), .nRST(nrst),
    .iREN(iren), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dren), .dWEN(dwen), .daddr(daddr), .dstore(dstore), .dwait(dwait), .dload(dload),
    .ramREN(ramren), .ramWEN(ramwen), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .ramerr(ramerr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, check outputs against the model, then advance the model.
  task automatic step(input logic rst_n, input logic ir, input logic dr, input logic dw,
                      input logic [31:0] ia, input logic [31:0] da, input logic [31:0] ds,
                      input logic [31:0] rl, input logic [1:0] rs);
    logic        d_on, i_on, acc;
    logic [31:0] e_addr, e_store, e_iload, e_dload;
    logic        e_ren, e_wen, e_iwait, e_dwait;
    @(negedge clk);
    nrst = rst_n; iren = ir; dren = dr; dwen = dw;
    iaddr = ia; daddr = da; dstore = ds; ramload = rl; ramstate = rs;
    if (!rst_n) begin owner = 0; streak = 0; err = 1'b0; end
    #1;
    acc  = (rs == 2'd2);
    d_on = (owner == 1) && (dr || dw);
    i_on = (owner == 2) && ir;
    e_ren   = d_on ? (dr && !dw) : i_on;
    e_wen   = d_on && dw;
    e_addr  = d_on ? da : (i_on ? ia : 32'd0);
    e_store = d_on ? ds : 32'd0;
    e_dwait = !(d_on && acc);
    e_iwait = !(i_on && acc);
    e_dload = (d_on && acc) ? rl : 32'd0;
    e_iload = (i_on && acc) ? rl : 32'd0;
    chk("ramREN",   32'(ramren),   32'(e_ren));
    chk("ramWEN",   32'(ramwen),   32'(e_wen));
    chk("ramaddr",  ramaddr,       e_addr);
    chk("ramstore", ramstore,      e_store);
    chk("dwait",    32'(dwait),    32'(e_dwait));
    chk("iwait",    32'(iwait),    32'(e_iwait));
    chk("dload",    dload,         e_dload);
    chk("iload",    iload,         e_iload);
    chk("ramerr",   32'(ramerr),   32'(err));
    chk("one_req",  32'(ramren & ramwen), 32'd0);
    @(posedge clk);
    if (rst_n) begin
      case (owner)
        0: if ((dr || dw) && !(ir && streak == DMAX)) owner = 1;
           else if (ir) owner = 2;
        1: if (!(dr || dw)) owner = 0;
           else if (rs == 2'd3) err = 1'b1;
           else if (acc && da[2]) begin
             owner  = 0;
             streak = ir ? ((streak + 1 > DMAX) ? DMAX : streak + 1) : 0;
           end
        2: if (!ir) owner = 0;
           else if (rs == 2'd3) err = 1'b1;
           else if (acc) begin owner = 0; streak = 0; end
        default: owner = 0;
      endcase
    end
  endtask

  initial begin
    logic [1:0]  rs;
    logic [31:0] a;
    int pi, pd, r;
    nrst = 1'b0; iren = 1'b0; dren = 1'b0; dwen = 1'b0;
    iaddr = '0; daddr = '0; dstore = '0; ramload = '0; ramstate = '0;
    step(1'b0, 0, 0, 0, 0, 0, 0, 32'h1111_1111, 2'd2);
    step(1'b1, 0, 0, 0, 0, 0, 0, 32'h1111_1111, 2'd2);

    // Priority and block lock: two dcache words with 2 BUSY cycles each, icache held.
    step(1'b1, 1, 1, 0, 32'h40, 32'h100, 0, 32'h0, 2'd0);
    for (int w = 0; w < 2; w++) begin
      a = (w == 0) ? 32'h100 : 32'h104;
      step(1'b1, 1, 1, 0, 32'h40, a, 0, 32'h0, 2'd1);
      step(1'b1, 1, 1, 0, 32'h40, a, 0, 32'h0, 2'd1);
      step(1'b1, 1, 1, 0, 32'h40, a, 0, 32'hA000_0000 + a, 2'd2);
    end
    step(1'b1, 1, 0, 0, 32'h40, 0, 0, 32'h0, 2'd0);
    step(1'b1, 1, 0, 0, 32'h40, 0, 0, 32'h1234_5678, 2'd2);

    // Fairness: back-to-back dcache blocks with icache held until it is finally served.
    for (int b = 0; b < 6; b++) begin
      step(1'b1, 1, 1, 0, 32'h80, 32'h300 + 8 * b, 0, 32'h0, 2'd0);
      step(1'b1, 1, 1, 0, 32'h80, 32'h300 + 8 * b, 0, 32'h5, 2'd2);
      step(1'b1, 1, 1, 0, 32'h80, 32'h304 + 8 * b, 0, 32'h6, 2'd2);
    end

    // Write with ACCESS on the third granted cycle, then icache ERROR twice then ACCESS.
    step(1'b1, 0, 0, 1, 0, 32'h200, 32'hDEAD_BEEF, 0, 2'd0);
    step(1'b1, 0, 0, 1, 0, 32'h204, 32'hDEAD_BEEF, 0, 2'd1);
    step(1'b1, 0, 0, 1, 0, 32'h204, 32'hDEAD_BEEF, 0, 2'd1);
    step(1'b1, 0, 0, 1, 0, 32'h204, 32'hDEAD_BEEF, 0, 2'd2);
    step(1'b1, 1, 0, 0, 32'h44, 0, 0, 0, 2'd0);
    step(1'b1, 1, 0, 0, 32'h44, 0, 0, 0, 2'd3);
    step(1'b1, 1, 0, 0, 32'h44, 0, 0, 0, 2'd3);
    step(1'b1, 1, 0, 0, 32'h44, 0, 0, 32'hCAFE_0001, 2'd2);
    step(1'b1, 0, 0, 0, 0, 0, 0, 0, 2'd0);

    // Reset in the middle of a dcache grant.
    step(1'b1, 0, 1, 0, 0, 32'h500, 0, 0, 2'd1);
    step(1'b1, 0, 1, 0, 0, 32'h500, 0, 0, 2'd1);
    step(1'b0, 0, 1, 0, 0, 32'h500, 0, 32'h77, 2'd2);
    step(1'b1, 0, 1, 0, 0, 32'h500, 0, 32'h77, 2'd2);
    step(1'b1, 0, 1, 0, 0, 32'h504, 0, 32'h78, 2'd2);

    // Random traffic in phases of different request pressure.
    for (int ph = 0; ph < 8; ph++) begin
      pi = (ph % 2) ? 95 : 50;
      pd = (ph % 4 < 2) ? 85 : 40;
      for (int c = 0; c < 300; c++) begin
        r  = $urandom_range(0, 99);
        rs = (r < 40) ? 2'd2 : (r < 70) ? 2'd1 : (r < 93) ? 2'd0 : 2'd3;
        step(($urandom_range(0, 99) != 0),
             ($urandom_range(0, 99) < pi),
             ($urandom_range(0, 99) < pd),
             ($urandom_range(0, 99) < 25),
             $urandom, {$urandom_range(0, 15), 3'($urandom_range(0, 1)) << 2, 2'b00} & 32'h7C,
             $urandom, $urandom, rs);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter DSTREAK_MAX, default 4: the number of consecutive dcache grants allowed while icache waits.
REQ-002 The block SHALL have these clock and reset ports: CLK (in, 1), system clock; nRST (in, 1), asynchronous active-low reset.
REQ-003 The block SHALL have these icache ports: iREN (in, 1), instruction read request; iaddr (in, 32), word address; iwait (out, 1), instruction not ready; iload (out, 32), instruction data.
REQ-004 The block SHALL have these dcache ports: dREN (in, 1) and dWEN (in, 1), data read and write requests; daddr (in, 32); dstore (in, 32); dwait (out, 1), data not ready; dload (out, 32), read data.
REQ-005 The block SHALL have these RAM ports: ramREN (out, 1); ramWEN (out, 1); ramaddr (out, 32); ramstore (out, 32); ramload (in, 32); ramstate (in, 2), with FREE=0, BUSY=1, ACCESS=2, ERROR=3.
REQ-006 The block SHALL have the output ramerr (out, 1): sticky flag, set when ERROR is seen while a grant is active.

Function
REQ-007 The block SHALL implement an FSM with states IDLE, DGRANT and IGRANT, plus a registered streak counter dstreak (3 bits, saturating at DSTREAK_MAX).
REQ-008 In IDLE, ramREN, ramWEN, ramaddr and ramstore SHALL be 0, and iwait and dwait SHALL be 1.
REQ-009 Arbitration in IDLE SHALL work as follows: if (dREN|dWEN) and not (iREN and dstreak==DSTREAK_MAX), go to DGRANT; else if iREN, go to IGRANT; else stay in IDLE. The decision is registered, giving exactly one cycle of arbitration latency.
REQ-010 In DGRANT, the block SHALL drive ramREN=dREN, ramWEN=dWEN, ramaddr=daddr and ramstore=dstore combinationally. If dREN and dWEN are both 1, ramWEN wins and ramREN is driven 0.
REQ-011 In DGRANT, dwait SHALL be 0 only in cycles where ramstate==ACCESS; dload SHALL equal ramload in those cycles.
REQ-012 On an ACCESS in DGRANT with daddr[2]==0 (first word of a block), the FSM SHALL stay in DGRANT (block lock) so the second word follows without icache interleaving.
REQ-013 On an ACCESS in DGRANT with daddr[2]==1, the FSM SHALL go to IDLE; dstreak SHALL increment (saturating) if iREN==1, else clear to 0.
REQ-014 If dREN and dWEN are both 0 while in DGRANT, the FSM SHALL go to IDLE next cycle with no RAM request driven in that cycle (dcache abort or lock release).
REQ-015 In IGRANT, the block SHALL drive ramREN=1, ramWEN=0 and ramaddr=iaddr. iwait SHALL be 0 and iload=ramload only when ramstate==ACCESS; the FSM SHALL then go to IDLE and clear dstreak.
REQ-016 If iREN drops while in IGRANT, the FSM SHALL go to IDLE next cycle.
REQ-017 For a non-granted cache, wait SHALL stay 1 and load SHALL be 0.
REQ-018 While granted, ramstate FREE, BUSY or ERROR SHALL keep wait=1. ERROR additionally sets ramerr, which stays set until reset; the grant is held.
REQ-019 Only one of ramREN or ramWEN SHALL ever be 1 in any cycle.

Reset
REQ-020 When nRST is asserted (asynchronously), the block SHALL force: state=IDLE, dstreak=0, ramerr=0, iwait=1, dwait=1, all RAM outputs 0, and iload=dload=0.
REQ-021 If reset is asserted during a grant, the block SHALL abandon the transfer with no completion signalled; after release, arbitration restarts from IDLE.

Verification
REQ-022 Priority: dREN=1 and iREN=1 simultaneously from IDLE, dstreak=0 -> DGRANT, ramaddr=daddr, and iwait stays 1 until the dcache transfer ends.
REQ-023 Block lock: dcache reads 0x100 then 0x104, with ACCESS after 2 BUSY cycles each and iREN held -> no icache grant between the two words, dwait low exactly twice, then IGRANT.
REQ-024 Fairness: dcache requests back-to-back for 4 blocks with iREN held -> the fifth arbitration grants icache, then dstreak=0.
REQ-025 Write path: dWEN=1, daddr=0x200, dstore=0xDEADBEEF, with ACCESS in cycle 3 -> ramWEN=1, ramstore=0xDEADBEEF, ramREN=0, dwait=0 only in cycle 3.
REQ-026 Error: ramstate=ERROR for 2 cycles then ACCESS during IGRANT -> iwait=1 during ERROR, ramerr=1 and sticky, completion on ACCESS.
REQ-027 Reset mid-grant: nRST pulsed low during DGRANT BUSY -> outputs go to reset values immediately, then IDLE after release, with no spurious dwait=0.
